wishbone_master: RTL

//  Single-transfer Wishbone classic initiator: the bus-side counterpart to the wishbone_slave memory port.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_timeout_counter.sv | 31 +++
 rtl/wishbone_master.sv | 98 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, address-field positions and FSM state encoding for the
// single-transfer Wishbone classic initiator.
package wb_pkg;

  localparam int WB_ADR_W  = 16;
  localparam int WB_DAT_W  = 8;
  localparam int WB_SEL_HI = 15;
  localparam int WB_SEL_LO = 12;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Slave-select field of a bus address.
  function automatic logic [WB_SEL_HI-WB_SEL_LO:0] wb_sel(input logic [WB_ADR_W-1:0] adr);
    return adr[WB_SEL_HI:WB_SEL_LO];
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating up-counter that flags when a bus cycle has waited TIMEOUT cycles
// without an acknowledge.
module wb_timeout_counter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == LAST);

  // Saturates on LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wishbone_master.sv
// Wishbone classic initiator: issues one read or write per client request,
// returns read data on ack, and aborts with err_o if no ack arrives in time.
module wishbone_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                req_we_i,
  input  logic [WB_ADR_W-1:0] req_adr_i,
  input  logic [WB_DAT_W-1:0] req_dat_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [WB_DAT_W-1:0] rdata_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [WB_ADR_W-1:0] adr_o,
  output logic [WB_DAT_W-1:0] dat_o,
  input  logic [WB_DAT_W-1:0] dat_i,
  input  logic                ack_i
);

  state_t state;
  logic   ack_hit;
  logic   expired;

  // A floating ack from an unmapped slave must never count as an acknowledge.
  assign ack_hit = (ack_i == 1'b1);
  assign busy_o  = (state != ST_IDLE);
  assign stb_o   = cyc_o;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state != ST_BUS),
    .enable  ((state == ST_BUS) && !ack_hit),
    .expired (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cyc_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      rdata_o <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            adr_o <= req_adr_i;
            dat_o <= req_dat_i;
            we_o  <= req_we_i;
            cyc_o <= 1'b1;
            state <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (ack_hit) begin
            cyc_o  <= 1'b0;
            done_o <= 1'b1;
            if (!we_o) begin
              rdata_o <= dat_i;
            end
            state <= ST_DONE;
          end else if (expired) begin
            cyc_o  <= 1'b0;
            done_o <= 1'b1;
            err_o  <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          cyc_o <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
